// File: rtl/writeback_queue.sv
// writeback_queue: in-order buffer for register-file writes from the memory
// and ALU writeback paths. It drains one entry per cycle into a registered
// write port, and forwards the newest pending value for two lookup addresses
// so decode can see writes that have not reached the register file yet.
module writeback_queue #(
  parameter int DEPTH = 4,
  parameter int AW    = 5,
  parameter int DW    = 32
) (
  input  logic                     clk,
  input  logic                     rst,

  input  logic                     mem_valid,
  input  logic [AW-1:0]            mem_reg,
  input  logic [DW-1:0]            mem_data,
  output logic                     mem_ready,

  input  logic                     alu_valid,
  input  logic [AW-1:0]            alu_reg,
  input  logic [DW-1:0]            alu_data,
  output logic                     alu_ready,

  input  logic                     drain_en,
  output logic                     EnableWrite,
  output logic [AW-1:0]            write_reg,
  output logic [DW-1:0]            write_data,

  input  logic [AW-1:0]            lookup_reg1,
  input  logic [AW-1:0]            lookup_reg2,
  output logic                     fwd_hit1,
  output logic                     fwd_hit2,
  output logic [DW-1:0]            fwd_data1,
  output logic [DW-1:0]            fwd_data2,

  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  // Queue storage. Entries are not reset; validity is implied by head/count.
  logic [AW-1:0] ent_reg_q  [DEPTH];
  logic [DW-1:0] ent_data_q [DEPTH];

  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;

  logic          we_q;
  logic [AW-1:0] wreg_q;
  logic [DW-1:0] wdata_q;

  logic [CW-1:0] free;
  logic          mem_push;
  logic          alu_push;
  logic          pop;
  logic [PW-1:0] alu_slot;

  // Per-slot view in age order: slot 0 is the head (oldest).
  logic [PW-1:0] slot_idx  [DEPTH];
  logic          slot_live [DEPTH];

  // Handshake: free space is judged on the count before this edge, so a
  // same-edge pop never makes room for an extra push.
  always_comb begin
    free      = CW'(DEPTH) - count_q;
    mem_ready = !rst && (free >= CW'(1));
    alu_ready = !rst && ((free >= CW'(2)) || ((free == CW'(1)) && !mem_valid));
    // Register 0 is a discard target: the request is accepted but not stored.
    mem_push  = mem_valid && mem_ready && (mem_reg != '0);
    alu_push  = alu_valid && alu_ready && (alu_reg != '0);
    pop       = !rst && drain_en && (count_q != '0);
  end

  // Pointer and occupancy next-state; the mem entry (older) lands first.
  always_comb begin
    alu_slot = tail_q + PW'(mem_push);
    tail_d   = tail_q + PW'(mem_push) + PW'(alu_push);
    head_d   = head_q + PW'(pop);
    count_d  = count_q + CW'(mem_push) + CW'(alu_push) - CW'(pop);
  end

  // Pointer and occupancy registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Entry writes; mem goes to tail, ALU to the slot after it when both push.
  always_ff @(posedge clk) begin
    if (mem_push) begin
      ent_reg_q[tail_q]  <= mem_reg;
      ent_data_q[tail_q] <= mem_data;
    end
    if (alu_push) begin
      ent_reg_q[alu_slot]  <= alu_reg;
      ent_data_q[alu_slot] <= alu_data;
    end
  end

  // Registered register-file write port; address/data hold when idle.
  always_ff @(posedge clk) begin
    if (rst) begin
      we_q    <= 1'b0;
      wreg_q  <= '0;
      wdata_q <= '0;
    end else begin
      we_q <= pop;
      if (pop) begin
        wreg_q  <= ent_reg_q[head_q];
        wdata_q <= ent_data_q[head_q];
      end
    end
  end

  // Map age order onto physical slots and flag the occupied ones.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      slot_idx[i]  = head_q + PW'(i);
      slot_live[i] = (CW'(i) < count_q);
    end
  end

  // Forwarding: the output register is the oldest candidate, then queue
  // entries from head to tail; later matches override earlier ones, so the
  // youngest pending write wins.
  always_comb begin
    fwd_hit1  = 1'b0;
    fwd_data1 = '0;
    if (lookup_reg1 != '0) begin
      if (we_q && (wreg_q == lookup_reg1)) begin
        fwd_hit1  = 1'b1;
        fwd_data1 = wdata_q;
      end
      for (int i = 0; i < DEPTH; i++) begin
        if (slot_live[i] && (ent_reg_q[slot_idx[i]] == lookup_reg1)) begin
          fwd_hit1  = 1'b1;
          fwd_data1 = ent_data_q[slot_idx[i]];
        end
      end
    end
  end

  // Second forwarding port, same priority as the first.
  always_comb begin
    fwd_hit2  = 1'b0;
    fwd_data2 = '0;
    if (lookup_reg2 != '0) begin
      if (we_q && (wreg_q == lookup_reg2)) begin
        fwd_hit2  = 1'b1;
        fwd_data2 = wdata_q;
      end
      for (int i = 0; i < DEPTH; i++) begin
        if (slot_live[i] && (ent_reg_q[slot_idx[i]] == lookup_reg2)) begin
          fwd_hit2  = 1'b1;
          fwd_data2 = ent_data_q[slot_idx[i]];
        end
      end
    end
  end

  // Status outputs.
  always_comb begin
    EnableWrite = we_q;
    write_reg   = wreg_q;
    write_data  = wdata_q;
    count       = count_q;
    full        = (count_q == CW'(DEPTH));
    empty       = (count_q == '0);
  end

  // Occupancy can never exceed the queue size.
  a_count_bound: assert property (@(posedge clk) disable iff (rst)
    count_q <= CW'(DEPTH));

  // A dual push needs two free slots.
  a_dual_room: assert property (@(posedge clk) disable iff (rst)
    !(mem_push && alu_push && (free < CW'(2))));

  // A pop only ever happens from a non-empty queue.
  a_pop_nonempty: assert property (@(posedge clk) disable iff (rst)
    !(pop && (count_q == '0)));

endmodule

// File: tb/tb_writeback_queue.sv
module tb_writeback_queue;
  localparam int DEPTH = 4;
  localparam int AW    = 5;
  localparam int DW    = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          mem_valid, alu_valid, drain_en;
  logic [AW-1:0] mem_reg, alu_reg, lookup_reg1, lookup_reg2;
  logic [DW-1:0] mem_data, alu_data;
  logic          mem_ready, alu_ready;
  logic          EnableWrite;
  logic [AW-1:0] write_reg;
  logic [DW-1:0] write_data;
  logic          fwd_hit1, fwd_hit2;
  logic [DW-1:0] fwd_data1, fwd_data2;
  logic [2:0]    count;
  logic          full, empty;

  int n_cmp = 0;
  int n_bad = 0;

  writeback_queue #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
    .clk(clk), .rst(rst),
    .mem_valid(mem_valid), .mem_reg(mem_reg), .mem_data(mem_data), .mem_ready(mem_ready),
    .alu_valid(alu_valid), .alu_reg(alu_reg), .alu_data(alu_data), .alu_ready(alu_ready),
    .drain_en(drain_en), .EnableWrite(EnableWrite), .write_reg(write_reg), .write_data(write_data),
    .lookup_reg1(lookup_reg1), .lookup_reg2(lookup_reg2),
    .fwd_hit1(fwd_hit1), .fwd_hit2(fwd_hit2), .fwd_data1(fwd_data1), .fwd_data2(fwd_data2),
    .count(count), .full(full), .empty(empty)
  );

  always #5 clk = ~clk;

  // Inputs change just after a negedge; checks run 1 time unit later.
  task automatic test_reset();
    rst = 1; drain_en = 1;
    mem_valid = 1; mem_reg = 3; mem_data = 33;
    alu_valid = 1; alu_reg = 4; alu_data = 44;
    #1;
    n_cmp++; if (mem_ready !== 1'b0) begin n_bad++; $display("FAIL reset_mem_ready: got %0b want 0", mem_ready); end
    n_cmp++; if (alu_ready !== 1'b0) begin n_bad++; $display("FAIL reset_alu_ready: got %0b want 0", alu_ready); end
    @(negedge clk); @(negedge clk); #1;
    n_cmp++; if (count !== 3'd0) begin n_bad++; $display("FAIL reset_count: got %0d want 0", count); end
    n_cmp++; if (empty !== 1'b1) begin n_bad++; $display("FAIL reset_empty: got %0b want 1", empty); end
    n_cmp++; if (full !== 1'b0) begin n_bad++; $display("FAIL reset_full: got %0b want 0", full); end
    n_cmp++; if (EnableWrite !== 1'b0) begin n_bad++; $display("FAIL reset_we: got %0b want 0", EnableWrite); end
    n_cmp++; if (write_reg !== 5'd0) begin n_bad++; $display("FAIL reset_wreg: got %0d want 0", write_reg); end
    n_cmp++; if (write_data !== 32'd0) begin n_bad++; $display("FAIL reset_wdata: got %0d want 0", write_data); end
    rst = 0; mem_valid = 0; alu_valid = 0; drain_en = 0;
    #1;
    n_cmp++; if (mem_ready !== 1'b1) begin n_bad++; $display("FAIL release_mem_ready: got %0b want 1", mem_ready); end
    n_cmp++; if (alu_ready !== 1'b1) begin n_bad++; $display("FAIL release_alu_ready: got %0b want 1", alu_ready); end
    @(negedge clk);
  endtask

  task automatic test_single_alu();
    drain_en = 1; lookup_reg1 = 9;
    alu_valid = 1; alu_reg = 9; alu_data = 41;
    #1;
    n_cmp++; if (fwd_hit1 !== 1'b0) begin n_bad++; $display("FAIL single_prehit: got %0b want 0", fwd_hit1); end
    @(negedge clk); alu_valid = 0; #1;
    n_cmp++; if (count !== 3'd1) begin n_bad++; $display("FAIL single_count: got %0d want 1", count); end
    n_cmp++; if (fwd_hit1 !== 1'b1) begin n_bad++; $display("FAIL single_hit_q: got %0b want 1", fwd_hit1); end
    n_cmp++; if (fwd_data1 !== 32'd41) begin n_bad++; $display("FAIL single_data_q: got %0d want 41", fwd_data1); end
    n_cmp++; if (EnableWrite !== 1'b0) begin n_bad++; $display("FAIL single_we_early: got %0b want 0", EnableWrite); end
    @(negedge clk); #1;
    n_cmp++; if (EnableWrite !== 1'b1) begin n_bad++; $display("FAIL single_we: got %0b want 1", EnableWrite); end
    n_cmp++; if (write_reg !== 5'd9) begin n_bad++; $display("FAIL single_wreg: got %0d want 9", write_reg); end
    n_cmp++; if (write_data !== 32'd41) begin n_bad++; $display("FAIL single_wdata: got %0d want 41", write_data); end
    n_cmp++; if (fwd_hit1 !== 1'b1) begin n_bad++; $display("FAIL single_hit_out: got %0b want 1", fwd_hit1); end
    n_cmp++; if (fwd_data1 !== 32'd41) begin n_bad++; $display("FAIL single_data_out: got %0d want 41", fwd_data1); end
    @(negedge clk); #1;
    n_cmp++; if (EnableWrite !== 1'b0) begin n_bad++; $display("FAIL single_we_off: got %0b want 0", EnableWrite); end
    n_cmp++; if (fwd_hit1 !== 1'b0) begin n_bad++; $display("FAIL single_hit_gone: got %0b want 0", fwd_hit1); end
    n_cmp++; if (fwd_data1 !== 32'd0) begin n_bad++; $display("FAIL single_data_gone: got %0d want 0", fwd_data1); end
    drain_en = 0;
    @(negedge clk);
  endtask

  task automatic test_dual_push();
    lookup_reg1 = 10; lookup_reg2 = 11; drain_en = 0;
    mem_valid = 1; mem_reg = 10; mem_data = 4;
    alu_valid = 1; alu_reg = 10; alu_data = 99;
    #1;
    n_cmp++; if (alu_ready !== 1'b1) begin n_bad++; $display("FAIL dual_alu_ready: got %0b want 1", alu_ready); end
    @(negedge clk); mem_valid = 0; alu_valid = 0; #1;
    n_cmp++; if (count !== 3'd2) begin n_bad++; $display("FAIL dual_count: got %0d want 2", count); end
    n_cmp++; if (fwd_data1 !== 32'd99) begin n_bad++; $display("FAIL dual_fwd_q: got %0d want 99", fwd_data1); end
    n_cmp++; if (fwd_hit2 !== 1'b0) begin n_bad++; $display("FAIL dual_hit2: got %0b want 0", fwd_hit2); end
    drain_en = 1;
    @(negedge clk); #1;
    n_cmp++; if (EnableWrite !== 1'b1) begin n_bad++; $display("FAIL dual_we1: got %0b want 1", EnableWrite); end
    n_cmp++; if (write_data !== 32'd4) begin n_bad++; $display("FAIL dual_first: got %0d want 4", write_data); end
    n_cmp++; if (fwd_data1 !== 32'd99) begin n_bad++; $display("FAIL dual_fwd_mid: got %0d want 99", fwd_data1); end
    @(negedge clk); #1;
    n_cmp++; if (write_data !== 32'd99) begin n_bad++; $display("FAIL dual_second: got %0d want 99", write_data); end
    n_cmp++; if (fwd_data1 !== 32'd99) begin n_bad++; $display("FAIL dual_fwd_out: got %0d want 99", fwd_data1); end
    n_cmp++; if (count !== 3'd0) begin n_bad++; $display("FAIL dual_count_end: got %0d want 0", count); end
    @(negedge clk); #1;
    n_cmp++; if (EnableWrite !== 1'b0) begin n_bad++; $display("FAIL dual_we_off: got %0b want 0", EnableWrite); end
    drain_en = 0;
    @(negedge clk);
  endtask

  task automatic test_full();
    logic exp_rdy;
    drain_en = 0; lookup_reg2 = 3;
    for (int i = 1; i <= 5; i++) begin
      alu_valid = 1; alu_reg = AW'(i); alu_data = DW'(10 + i);
      #1;
      exp_rdy = (i <= 4);
      n_cmp++; if (alu_ready !== exp_rdy) begin n_bad++; $display("FAIL full_alu_ready_%0d: got %0b want %0b", i, alu_ready, exp_rdy); end
      if (i < 5) @(negedge clk);
    end
    n_cmp++; if (full !== 1'b1) begin n_bad++; $display("FAIL full_flag: got %0b want 1", full); end
    n_cmp++; if (count !== 3'd4) begin n_bad++; $display("FAIL full_count: got %0d want 4", count); end
    n_cmp++; if (mem_ready !== 1'b0) begin n_bad++; $display("FAIL full_mem_ready: got %0b want 0", mem_ready); end
    n_cmp++; if (fwd_data2 !== 32'd13) begin n_bad++; $display("FAIL full_fwd2: got %0d want 13", fwd_data2); end
    drain_en = 1;
    @(negedge clk); #1;
    n_cmp++; if (write_data !== 32'd11) begin n_bad++; $display("FAIL full_w11: got %0d want 11", write_data); end
    n_cmp++; if (count !== 3'd3) begin n_bad++; $display("FAIL full_cnt_a: got %0d want 3", count); end
    n_cmp++; if (alu_ready !== 1'b1) begin n_bad++; $display("FAIL full_ready_back: got %0b want 1", alu_ready); end
    @(negedge clk); alu_valid = 0; #1;
    n_cmp++; if (write_data !== 32'd12) begin n_bad++; $display("FAIL full_w12: got %0d want 12", write_data); end
    n_cmp++; if (count !== 3'd3) begin n_bad++; $display("FAIL full_cnt_b: got %0d want 3", count); end
    @(negedge clk); #1;
    n_cmp++; if (write_data !== 32'd13) begin n_bad++; $display("FAIL full_w13: got %0d want 13", write_data); end
    @(negedge clk); #1;
    n_cmp++; if (write_data !== 32'd14) begin n_bad++; $display("FAIL full_w14: got %0d want 14", write_data); end
    @(negedge clk); #1;
    n_cmp++; if (write_data !== 32'd15) begin n_bad++; $display("FAIL full_w15: got %0d want 15", write_data); end
    n_cmp++; if (write_reg !== 5'd5) begin n_bad++; $display("FAIL full_wreg5: got %0d want 5", write_reg); end
    n_cmp++; if (count !== 3'd0) begin n_bad++; $display("FAIL full_cnt_end: got %0d want 0", count); end
    @(negedge clk); #1;
    n_cmp++; if (EnableWrite !== 1'b0) begin n_bad++; $display("FAIL full_we_off: got %0b want 0", EnableWrite); end
    drain_en = 0;
    @(negedge clk);
  endtask

  task automatic test_reg0();
    drain_en = 1; lookup_reg1 = 0;
    alu_valid = 1; alu_reg = 0; alu_data = 7;
    #1;
    n_cmp++; if (alu_ready !== 1'b1) begin n_bad++; $display("FAIL reg0_ready: got %0b want 1", alu_ready); end
    @(negedge clk); alu_valid = 0; #1;
    n_cmp++; if (count !== 3'd0) begin n_bad++; $display("FAIL reg0_count: got %0d want 0", count); end
    n_cmp++; if (fwd_hit1 !== 1'b0) begin n_bad++; $display("FAIL reg0_hit: got %0b want 0", fwd_hit1); end
    @(negedge clk); #1;
    n_cmp++; if (EnableWrite !== 1'b0) begin n_bad++; $display("FAIL reg0_we: got %0b want 0", EnableWrite); end
    drain_en = 0;
    @(negedge clk);
  endtask

  int exp_cnt[4] = '{0, 2, 3, 3};
  int exp_seq[6] = '{100, 150, 101, 151, 102, 103};

  task automatic test_back_to_back();
    int got[$];
    logic exp_rdy;
    drain_en = 1;
    for (int c = 0; c < 4; c++) begin
      if (EnableWrite === 1'b1) got.push_back(int'(write_data));
      mem_valid = 1; mem_reg = AW'(c + 1); mem_data = DW'(100 + c);
      alu_valid = 1; alu_reg = AW'(c + 8); alu_data = DW'(150 + c);
      #1;
      exp_rdy = (c < 2);
      n_cmp++; if (count !== 3'(exp_cnt[c])) begin n_bad++; $display("FAIL b2b_count_%0d: got %0d want %0d", c, count, exp_cnt[c]); end
      n_cmp++; if (alu_ready !== exp_rdy) begin n_bad++; $display("FAIL b2b_alu_ready_%0d: got %0b want %0b", c, alu_ready, exp_rdy); end
      n_cmp++; if (mem_ready !== 1'b1) begin n_bad++; $display("FAIL b2b_mem_ready_%0d: got %0b want 1", c, mem_ready); end
      @(negedge clk);
    end
    mem_valid = 0; alu_valid = 0;
    for (int k = 0; k < 6; k++) begin
      if (EnableWrite === 1'b1) got.push_back(int'(write_data));
      @(negedge clk);
    end
    n_cmp++; if (got.size() != 6) begin n_bad++; $display("FAIL b2b_drain_len: got %0d want 6", got.size()); end
    for (int i = 0; i < 6 && i < got.size(); i++) begin
      n_cmp++; if (got[i] != exp_seq[i]) begin n_bad++; $display("FAIL b2b_order_%0d: got %0d want %0d", i, got[i], exp_seq[i]); end
    end
    drain_en = 0;
  endtask

  task automatic test_reset_mid();
    drain_en = 0; lookup_reg1 = 21;
    mem_valid = 1; mem_reg = 20; mem_data = 200;
    alu_valid = 1; alu_reg = 21; alu_data = 201;
    @(negedge clk);
    mem_valid = 0; alu_reg = 22; alu_data = 202;
    @(negedge clk);
    alu_valid = 0; #1;
    n_cmp++; if (count !== 3'd3) begin n_bad++; $display("FAIL mid_count3: got %0d want 3", count); end
    drain_en = 1;
    @(negedge clk); #1;
    n_cmp++; if (write_data !== 32'd200) begin n_bad++; $display("FAIL mid_w200: got %0d want 200", write_data); end
    rst = 1;
    @(negedge clk); #1;
    n_cmp++; if (EnableWrite !== 1'b0) begin n_bad++; $display("FAIL mid_we: got %0b want 0", EnableWrite); end
    n_cmp++; if (count !== 3'd0) begin n_bad++; $display("FAIL mid_count0: got %0d want 0", count); end
    n_cmp++; if (write_reg !== 5'd0) begin n_bad++; $display("FAIL mid_wreg: got %0d want 0", write_reg); end
    n_cmp++; if (fwd_hit1 !== 1'b0) begin n_bad++; $display("FAIL mid_hit: got %0b want 0", fwd_hit1); end
    rst = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk); #1;
      n_cmp++; if (EnableWrite !== 1'b0) begin n_bad++; $display("FAIL mid_stale_%0d: got %0b want 0", k, EnableWrite); end
    end
    drain_en = 0;
  endtask

  initial begin
    rst = 1; mem_valid = 0; alu_valid = 0; drain_en = 0;
    mem_reg = 0; mem_data = 0; alu_reg = 0; alu_data = 0;
    lookup_reg1 = 0; lookup_reg2 = 0;
    test_reset();
    test_single_alu();
    test_dual_push();
    test_full();
    test_reg0();
    test_back_to_back();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/writeback_queue.md
# writeback_queue

Buffers register-file write requests from the ALU and memory writeback sources and drains them in program order, one per cycle, into the 32x32 register file write port (EnableWrite / write_reg / write_data). It also forwards the newest pending value for two read addresses, so decode sees writes that have not yet reached the register file. It sits between the EX/MEM writeback paths and the register file.

## Interface
- DEPTH, 4, queue entries; power of two, 2..16
- AW, 5, register address width
- DW, 32, data width
- clk  in  1  clock; all state updates on posedge
- rst  in  1  synchronous, active-high reset
- mem_valid / mem_reg / mem_data  in  1 / AW / DW  memory-stage write request (older instruction)
- mem_ready  out  1  memory request accepted this edge when mem_valid=1
- alu_valid / alu_reg / alu_data  in  1 / AW / DW  ALU-stage write request (younger instruction)
- alu_ready  out  1  ALU request accepted this edge when alu_valid=1
- drain_en  in  1  1 = head entry may be popped this edge
- EnableWrite  out  1  registered write strobe to register file
- write_reg  out  AW  registered write address
- write_data  out  DW  registered write data
- lookup_reg1, lookup_reg2  in  AW  forwarding lookup addresses
- fwd_hit1, fwd_hit2  out  1  combinational: pending write exists for address
- fwd_data1, fwd_data2  out  DW  combinational: newest pending data (0 when no hit)
- count  out  clog2(DEPTH)+1  entries held
- full, empty  out  1  count==DEPTH / count==0

## Operation
- Circular buffer: head/tail pointers wrap modulo DEPTH; count tracked explicitly.
- free = DEPTH - count, taken from the value before this edge; a same-edge pop does not raise free (conservative).
- mem_ready = !rst & (free >= 1).
- alu_ready = !rst & ((free >= 2) | (free == 1 & !mem_valid)).
- Same-edge dual push: mem entry enqueued first, ALU entry second; order preserved.
- A request with reg == 0 is handshaken (ready applies) but not enqueued; count unchanged.
- Pop: when drain_en=1 and count>0 at the edge, head entry loads write_reg/write_data and EnableWrite=1; otherwise EnableWrite=0 and write_reg/write_data hold their values.
- Push and pop on the same edge are both applied; count changes by pushes minus pops.
- Forwarding searches queue entries plus the output register while EnableWrite=1 (that write is not yet in the register file); the newest match wins in order ALU-most-recent, then older entries, then output register. lookup == 0 never hits.
- Reset: head=tail=count=0, EnableWrite=0, write_reg=0, write_data=0, empty=1, full=0, readies 0 while rst=1; pending entries are discarded.

## Timing
- Request accepted at edge N → earliest pop at edge N+1 → EnableWrite high in cycle N+1..N+2 → register file writes at edge N+2.
- Forwarding valid from cycle after edge N until the register file write at edge N+2 (or later if stalled).
- Throughput: one drain per cycle; sustained dual push with drain_en=1 settles at count=DEPTH-1, alu_ready deasserting every cycle mem_valid=1.
- drain_en=0 for k cycles with pushes → count saturates at DEPTH, full=1, both readies 0; no entry lost or overwritten.
- Reset mid-operation: the first cycle after the rst edge shows EnableWrite=0 and count=0 regardless of the prior state.

## Test plan
- Reset: assert rst 2 cycles with valids high → empty=1, count=0, EnableWrite=0, readies 0; after release alu_ready=mem_ready=1.
- Single ALU push reg 9 data 41 at edge N → fwd_hit1=1, fwd_data1=41 for lookup_reg1=9 from cycle N+1; EnableWrite=1, write_reg=9, write_data=41 in cycle after N+1.
- Dual push mem (reg 10, 4) and ALU (reg 10, 99) at the same edge → writes drained 4 then 99 on consecutive cycles; forwarding for reg 10 returns 99 until drained.
- drain_en=0, push 5 ALU entries (regs 1..5, data 11..15) → first 4 accepted, full=1, alu_ready=0 on 5th; drain_en=1 → writes 11,12,13,14 in order, then 5th accepted.
- ALU push reg 0 data 7 → alu_ready=1, count stays 0, no EnableWrite, lookup 0 never hits.
- Three entries pending, assert rst for 1 cycle → next cycle EnableWrite=0, count=0, no stale writes afterward.
